addsub32_byte_seq: RTL and testbench

Sequenced 32-bit add/subtract unit that time-shares one 8-bit ripple adder (`ripple_adder_8bit`) across four consecutive cycles, least-significant byte first, carrying between bytes through a register. Used wherever a 32-bit add/sub is needed at low area and a few cycles of latency is acceptable, such as a multi-cycle ALU fallback or an address-offset helper. Operands are taken over a valid/ready request port. Results and flags are returned over a valid/ready response port.

---
 rtl/addsub32_byte_seq.sv | 154 +++++++++++++++
 tb/tb_addsub32_byte_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub32_byte_seq.sv
// Sequenced 32-bit add/subtract built around a single 8-bit ripple adder.
// One byte slice is processed per cycle, LSB first, with the carry held in a register.

module ripple_adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] s_o,
    output logic       c_o
);

    logic [8:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = carry[8];

endmodule

module addsub32_byte_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        req_sub_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_sum_o,
    output logic        resp_carry_o,
    output logic        resp_ovf_o,
    output logic        resp_zero_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q, sum_q;
    logic        sub_q, carry_q;
    logic [1:0]  cnt_q;

    logic [31:0] res_sum_q;
    logic        res_carry_q, res_ovf_q, res_zero_q;

    logic        accept, step, last;
    logic [4:0]  slice_lsb;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_ci, add_co;

    // The first slice takes the subtract bit as carry-in to complete the two's complement.
    assign slice_lsb = {cnt_q, 3'b000};
    assign add_a     = a_q[slice_lsb +: 8];
    assign add_b     = b_q[slice_lsb +: 8];
    assign add_ci    = (cnt_q == 2'd0) ? sub_q : carry_q;

    ripple_adder_8bit u_adder (
        .a_i (add_a),
        .b_i (add_b),
        .c_i (add_ci),
        .s_o (add_s),
        .c_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == 2'd3) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= req_a_i;
            b_q     <= req_b_i ^ {32{req_sub_i}};
            sub_q   <= req_sub_i;
            cnt_q   <= '0;
        end else if (step) begin
            sum_q[slice_lsb +: 8] <= add_s;
            carry_q               <= add_co;
            cnt_q                 <= cnt_q + 2'd1;
        end
    end

    // Published results only move on the final slice, so they stay put while the next op runs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_zero_q  <= 1'b0;
        end else if (last) begin
            res_sum_q   <= {add_s, sum_q[23:0]};
            res_carry_q <= add_co;
            res_ovf_q   <= (a_q[31] == b_q[31]) & (add_s[7] != a_q[31]);
            res_zero_q  <= (sum_q[23:0] == 24'd0) & (add_s == 8'd0);
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == DONE);
    assign busy_o       = (state_q == CALC) || (state_q == DONE);
    assign resp_sum_o   = res_sum_q;
    assign resp_carry_o = res_carry_q;
    assign resp_ovf_o   = res_ovf_q;
    assign resp_zero_o  = res_zero_q;

endmodule

// File: tb/tb_addsub32_byte_seq.sv
// Scoreboard bench for addsub32_byte_seq: a reference model predicts each result at request time,
// and a monitor pops and compares whenever the DUT completes a response handshake.

module tb_addsub32_byte_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        req_sub_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_sum_o;
    logic        resp_carry_o;
    logic        resp_ovf_o;
    logic        resp_zero_o;
    logic        busy_o;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } expect_t;

    expect_t sbQ[$];
    expect_t monExp;
    int      checkCount = 0;
    int      errorCount = 0;

    addsub32_byte_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_sub_i    (req_sub_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_sum_o   (resp_sum_o),
        .resp_carry_o (resp_carry_o),
        .resp_ovf_o   (resp_ovf_o),
        .resp_zero_o  (resp_zero_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model written from the arithmetic definition rather than the slice structure.
    function automatic expect_t predict(input logic [31:0] a, input logic [31:0] b, input logic sub);
        expect_t     e;
        logic [32:0] wide;
        if (!sub) begin
            wide    = {1'b0, a} + {1'b0, b};
            e.sum   = wide[31:0];
            e.carry = wide[32];
            e.ovf   = (a[31] == b[31]) && (e.sum[31] != a[31]);
        end else begin
            e.sum   = a - b;
            e.carry = (a >= b);
            e.ovf   = (a[31] != b[31]) && (e.sum[31] != a[31]);
        end
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni && resp_valid_o && resp_ready_i) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_unexpected_resp", 32'd1, 32'd0);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("sb_sum",   resp_sum_o,   monExp.sum);
                checkOutput("sb_carry", resp_carry_o, monExp.carry);
                checkOutput("sb_ovf",   resp_ovf_o,   monExp.ovf);
                checkOutput("sb_zero",  resp_zero_o,  monExp.zero);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub, input bit track);
        int n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checkOutput("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_a_i     = a;
        req_b_i     = b;
        req_sub_i   = sub;
        req_valid_i = 1'b1;
        if (track) sbQ.push_back(predict(a, b, sub));
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while ((sbQ.size() != 0 || !req_ready_o) && n < 60) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput({tag, "_drained"}, 32'((sbQ.size() == 0) && req_ready_o), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"},  req_ready_o,  32'd1);
        checkOutput({tag, "_resp_valid"}, resp_valid_o, 32'd0);
        checkOutput({tag, "_busy"},       busy_o,       32'd0);
        checkOutput({tag, "_sum"},        resp_sum_o,   32'd0);
        checkOutput({tag, "_carry"},      resp_carry_o, 32'd0);
        checkOutput({tag, "_ovf"},        resp_ovf_o,   32'd0);
        checkOutput({tag, "_zero"},       resp_zero_o,  32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_a_i      = '0;
        req_b_i      = '0;
        req_sub_i    = 1'b0;
        resp_ready_i = 1'b1;
        #2;
        checkResetValues("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Byte carry chain plus latency from acceptance to resp_valid_o.
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        n = 0;
        while (!resp_valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput("latency_cycles", 32'(n), 32'd4);
        waitDrain("carry_chain");

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        waitDrain("unsigned_wrap");
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        waitDrain("sub_borrow");
        applyStimulus(32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1);
        waitDrain("sub_equal");
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        waitDrain("add_ovf");
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        waitDrain("sub_ovf");
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            waitDrain("random");
        end

        // Backpressure with a competing request held on the port the whole time.
        resp_ready_i = 1'b0;
        applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
        req_a_i     = 32'hAAAA_AAAA;
        req_b_i     = 32'h0000_0005;
        req_sub_i   = 1'b1;
        req_valid_i = 1'b1;
        n = 0;
        while (!resp_valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checkOutput("bp_valid_reached", resp_valid_o, 32'd1);
        repeat (10) begin
            @(posedge clk_i);
            #1;
            checkOutput("bp_hold_valid", resp_valid_o, 32'd1);
            checkOutput("bp_hold_sum",   resp_sum_o,   32'h3333_3333);
            checkOutput("bp_hold_ready", req_ready_o,  32'd0);
        end
        resp_ready_i = 1'b1;
        sbQ.push_back(predict(32'hAAAA_AAAA, 32'h0000_0005, 1'b1));
        @(posedge clk_i);
        #1;
        checkOutput("bp_release_ready", req_ready_o,  32'd1);
        checkOutput("bp_release_valid", resp_valid_o, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("bp_second_accepted", busy_o, 32'd1);
        req_valid_i = 1'b0;
        waitDrain("backpressure");

        // Asynchronous reset in the middle of CALC discards the operation.
        applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(32'd3, 32'd4, 1'b0, 1'b1);
        waitDrain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
